// File: rtl/alu_pkg.sv
// Shared ALU definitions: carry-in source encodings and decode helper.
package alu_pkg;

  typedef enum logic [1:0] {
    CSEL_ZERO  = 2'b00,
    CSEL_FLAG  = 2'b01,
    CSEL_ONE   = 2'b10,
    CSEL_ZERO2 = 2'b11
  } csel_e;

  function automatic logic carry_sel(
    input logic [1:0] sel,
    input logic       flag
  );
    logic r;
    r = 1'b0;
    unique case (csel_e'(sel))
      CSEL_FLAG: r = flag;
      CSEL_ONE:  r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One SLICE-bit ripple slice of the pipelined adder, purely combinational.
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined adder: one SLICE-bit slice per stage, valid/ready
// handshake, global stall and flag generation on the final stage.
module adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  input  logic             Subtract,
  input  logic [1:0]       CarrySelect,
  input  logic             CarryFlag,
  input  logic             FlagSource,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AdderOut,
  output logic             CarryOut,
  output logic             ZeroOut,
  output logic             NegOut,
  output logic             OverflowOut,
  output logic             CarryFlagReg
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int L = STAGES - 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic [STAGES-1:0] v_q;

  logic flag_q;
  logic zero_q;
  logic neg_q;
  logic ovf_q;
  logic stall;
  logic hazard;
  logic accept;
  logic fire;
  logic flag;
  logic cin;

  assign out_valid = v_q[L];
  assign stall     = out_valid && !out_ready;
  assign fire      = out_valid && out_ready;
  assign hazard    = in_valid && FlagSource
                  && (CarrySelect == CSEL_FLAG) && (|v_q);
  assign in_ready  = !rst && !stall && !hazard;
  assign accept    = in_valid && in_ready;
  assign flag      = FlagSource ? flag_q : CarryFlag;
  assign cin       = carry_sel(CarrySelect, flag);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic [SLICE-1:0] sl_sum;
    logic             sl_co;

    if (k == 0) begin : g_first
      assign a_i = LHS;
      assign b_i = Subtract ? ~RHS : RHS;
      assign s_i = '0;
      assign c_i = cin;
    end else begin : g_next
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign s_i = s_q[k-1];
      assign c_i = c_q[k-1];
    end

    adder_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a   (a_i[k*SLICE +: SLICE]),
      .b   (b_i[k*SLICE +: SLICE]),
      .cin (c_i),
      .sum (sl_sum),
      .cout(sl_co)
    );

    assign a_d[k] = a_i;
    assign b_d[k] = b_i;
    assign c_d[k] = sl_co;
    assign s_d[k] = (s_i & ~(SMASK << (k*SLICE)))
                  | (WIDTH'(sl_sum) << (k*SLICE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      flag_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      v_q <= (v_q << 1) | STAGES'(accept);
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      // Flags are formed as the last slice lands so they hold during stalls.
      zero_q <= (s_d[L] == '0);
      neg_q  <= s_d[L][MSB];
      ovf_q  <= (a_d[L][MSB] == b_d[L][MSB])
             && (s_d[L][MSB] != a_d[L][MSB]);
      if (fire) flag_q <= c_q[L];
    end
  end

  assign AdderOut     = s_q[L];
  assign CarryOut     = c_q[L];
  assign ZeroOut      = zero_q;
  assign NegOut       = neg_q;
  assign OverflowOut  = ovf_q;
  assign CarryFlagReg = flag_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Randomized + directed bench for adder_pipe against an arithmetic
// reference queue.
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] LHS = '0;
  logic [15:0] RHS = '0;
  logic        Subtract = 1'b0;
  logic [1:0]  CarrySelect = 2'b00;
  logic        CarryFlag = 1'b0;
  logic        FlagSource = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] AdderOut;
  logic        CarryOut;
  logic        ZeroOut;
  logic        NegOut;
  logic        OverflowOut;
  logic        CarryFlagReg;

  adder_pipe #(.WIDTH(16), .SLICE(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .LHS(LHS), .RHS(RHS), .Subtract(Subtract),
    .CarrySelect(CarrySelect), .CarryFlag(CarryFlag),
    .FlagSource(FlagSource),
    .out_valid(out_valid), .out_ready(out_ready),
    .AdderOut(AdderOut), .CarryOut(CarryOut),
    .ZeroOut(ZeroOut), .NegOut(NegOut),
    .OverflowOut(OverflowOut), .CarryFlagReg(CarryFlagReg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic co, z, n, ov;
  } exp_t;

  exp_t        q[$];
  logic        mflag = 1'b0;
  logic        last_acc;
  logic [15:0] last_out;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [15:0] l, r,
                                  input logic sub, cin);
    exp_t e;
    logic [15:0] b;
    logic [16:0] full;
    int t;
    b    = sub ? ~r : r;
    full = 17'(l) + 17'(b) + 17'(cin);
    t    = int'($signed(l)) + int'($signed(b)) + int'(cin);
    e.sum = full[15:0];
    e.co  = full[16];
    e.z   = (full[15:0] == 16'h0000);
    e.n   = full[15];
    e.ov  = (t > 32767) || (t < -32768);
    return e;
  endfunction

  function automatic logic ref_cin(input logic [1:0] cs,
                                   input logic cf, fs, fr);
    case (cs)
      2'b01:   return fs ? fr : cf;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_rdy = !rst && !(out_valid && !out_ready)
           && !(in_valid && FlagSource && CarrySelect == 2'b01
                && q.size() > 0);
    chk("in_ready", in_ready, exp_rdy);
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      mflag = 1'b0;
    end else begin
      chk("flagreg", CarryFlagReg, mflag);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious", out_valid, 0);
        else begin
          e = q[0];
          chk("sum", AdderOut, e.sum);
          chk("flags", {CarryOut, ZeroOut, NegOut, OverflowOut},
              {e.co, e.z, e.n, e.ov});
          if (out_ready) begin
            mflag = e.co;
            last_out = e.sum;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        q.push_back(ref_op(LHS, RHS, Subtract,
          ref_cin(CarrySelect, CarryFlag, FlagSource, mflag)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [15:0] l, r, input logic sub,
                       input logic [1:0] cs, input logic cf, fs,
                       output int waits);
    logic acc;
    LHS = l; RHS = r; Subtract = sub;
    CarrySelect = cs; CarryFlag = cf; FlagSource = fs;
    in_valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      tick();
      if (last_acc) acc = 1'b1;
      else waits++;
    end
    chk("issue_to", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int w;
    int acc_any;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_out", {AdderOut, CarryOut, ZeroOut, NegOut,
                    OverflowOut, CarryFlagReg}, 0);

    issue(16'h00FF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, w);
    chk("lat_mid", out_valid, 0);
    tick();
    chk("lat_out", out_valid, 1);
    chk("sum_0100", AdderOut, 16'h0100);
    chk("flg_0100", {CarryOut, ZeroOut, OverflowOut}, 3'b000);
    drain();

    issue(16'h0005, 16'h0005, 1'b1, 2'b10, 1'b0, 1'b0, w);
    drain();
    chk("sub_zero", last_out, 16'h0000);
    chk("sub_flag", CarryFlagReg, 1);

    issue(16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, w);
    issue(16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, w);
    drain();

    issue(16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, w);
    issue(16'h0000, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b1, w);
    chk("haz_wait", w > 0, 1);
    drain();
    chk("flag_chain", last_out, 16'h0001);

    out_ready = 1'b0;
    issue(16'h1234, 16'h1111, 1'b0, 2'b00, 1'b0, 1'b0, w);
    issue(16'h8000, 16'h8000, 1'b0, 2'b00, 1'b0, 1'b0, w);
    LHS = 16'h0001; RHS = 16'h0002; CarrySelect = 2'b10;
    in_valid = 1'b1;
    acc_any = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_acc) acc_any++;
    end
    chk("stall_blk", acc_any, 0);
    chk("stall_hold", AdderOut, 16'h2345);
    out_ready = 1'b1;
    issue(16'h0001, 16'h0002, 1'b0, 2'b10, 1'b0, 1'b0, w);
    drain();
    chk("order_last", last_out, 16'h0004);

    issue(16'hAAAA, 16'h5555, 1'b0, 2'b00, 1'b0, 1'b0, w);
    issue(16'h1000, 16'h0001, 1'b1, 2'b10, 1'b0, 1'b0, w);
    do_reset();
    chk("mid_rst_v", out_valid, 0);
    chk("mid_rst_o", {AdderOut, CarryOut, CarryFlagReg}, 0);
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        in_valid    = ($urandom_range(0, 3) != 0);
        LHS         = 16'($urandom);
        RHS         = 16'($urandom);
        Subtract    = 1'($urandom);
        CarrySelect = 2'($urandom);
        CarryFlag   = 1'($urandom);
        FlagSource  = ($urandom_range(0, 3) == 0);
        out_ready   = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits added per pipeline stage; WIDTH is a multiple of SLICE, SLICE >= 1.
REQ-003 SHALL have parameter STAGES = WIDTH/SLICE, derived, not overridable; pipeline depth.
REQ-004 SHALL have ports: clk in 1 sole clock, all state on rising edge; rst in 1 synchronous active-high reset.
REQ-005 SHALL have ports: in_valid in 1, operation offered; in_ready out 1, operation accepted when in_valid && in_ready.
REQ-006 SHALL have ports: LHS in WIDTH; RHS in WIDTH; Subtract in 1, invert RHS bitwise before add.
REQ-007 SHALL have ports: CarrySelect in 2, carry-in source; CarryFlag in 1, external carry flag; FlagSource in 1, 0 = external CarryFlag, 1 = internal flag register.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; AdderOut out WIDTH; CarryOut out 1; ZeroOut out 1; NegOut out 1; OverflowOut out 1; CarryFlagReg out 1, internal flag register.

Function
REQ-009 SHALL decode CarrySelect: 00 -> 0; 01 -> selected flag (per FlagSource); 10 -> 1; 11 -> 0.
REQ-010 SHALL compute {CarryOut, AdderOut} = LHS + (Subtract ? ~RHS : RHS) + carry-in, WIDTH+1-bit result, modulo 2^(WIDTH+1).
REQ-011 SHALL add slice k (bits k*SLICE .. k*SLICE+SLICE-1) in stage k, using carry from stage k-1 (stage 0 uses carry-in); operand slices not yet consumed and result slices already produced travel in skew registers.
REQ-012 SHALL have latency exactly STAGES cycles from accept to out_valid when not stalled; throughput one operation per cycle.
REQ-013 SHALL stall the whole pipeline (no register advances) when out_valid && !out_ready; AdderOut and all flags SHALL hold stable while stalled.
REQ-014 SHALL drive in_ready = !(out_valid && !out_ready) && !hazard.
REQ-015 SHALL define hazard = in_valid && FlagSource && CarrySelect==01 && any operation in flight (stage valid bits or output valid); hazard clears once the pipeline is empty.
REQ-016 SHALL set ZeroOut = (AdderOut == 0), NegOut = AdderOut[WIDTH-1], OverflowOut = signed overflow (operand MSBs equal after inversion, result MSB differs).
REQ-017 SHALL load CarryFlagReg with CarryOut on each output handshake (out_valid && out_ready), otherwise hold.
REQ-018 SHALL pass bubbles (in_valid low) through as invalid stages; result data for invalid stages is don't-care but flags SHALL only update on a handshake.
REQ-019 SHALL handle simultaneous accept and output handshake in one cycle with no loss or duplication.
REQ-020 SHALL, for STAGES = 1, behave as a single registered adder with latency 1.

Reset
REQ-021 SHALL, on rst high at a clock edge, clear all stage valid bits, out_valid = 0, CarryFlagReg = 0, AdderOut = 0, CarryOut/ZeroOut/NegOut/OverflowOut = 0.
REQ-022 SHALL discard all in-flight operations on rst mid-operation; no result for them ever appears.
REQ-023 SHALL drive in_ready = 0 while rst is high; inputs ignored.

Structure
REQ-024 SHALL place the CarrySelect encodings (CSEL_ZERO=00, CSEL_FLAG=01, CSEL_ONE=10, CSEL_ZERO2=11) in shared package alu_pkg.
REQ-025 SHALL instantiate one sub-module adder_slice (SLICE-bit add with carry-in/carry-out, combinational) per stage via generate.

Verification (WIDTH=16, SLICE=8, STAGES=2)
REQ-026 SHALL cover: LHS=0x00FF, RHS=0x0001, CarrySelect=00, Subtract=0 -> 2 cycles later AdderOut=0x0100, CarryOut=0, ZeroOut=0, OverflowOut=0.
REQ-027 SHALL cover: LHS=0x0005, RHS=0x0005, Subtract=1, CarrySelect=10 -> AdderOut=0x0000, CarryOut=1, ZeroOut=1; CarryFlagReg=1 after handshake.
REQ-028 SHALL cover: LHS=0x7FFF, RHS=0x0001, CarrySelect=00 -> AdderOut=0x8000, NegOut=1, OverflowOut=1; then LHS=0xFFFF, RHS=0x0001 -> 0x0000, CarryOut=1.
REQ-029 SHALL cover: back-to-back ops with FlagSource=1, CarrySelect=01 after 0xFFFF+0x0001 -> in_ready low until pipeline empty, then 0x0000+0x0000 yields 0x0001.
REQ-030 SHALL cover: out_ready held low 5 cycles with 3 ops issued -> outputs hold, in_ready low once full, all 3 results delivered in order; rst asserted mid-stream -> out_valid=0 next cycle, no stale results.
